pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised pipeline-stage register that replaces the fixed 16-bit fetch/decode latch with a generic payload register.
- Valid/ready handshake in both directions, with an optional two-entry skid buffer so upstream `in_ready` is driven from flops.
- Synchronous flush that converts held entries into bubbles.
- Sits between any two pipeline stages (IF/ID first); the payload is the concatenated PC and instruction.

## Interface
- `DATA_W`, 32, payload width in bits (≥1).
- `SKID`, 1, 1 = two-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.
- `BUBBLE`, `{DATA_W{1'b0}}`, payload value presented whenever the stage holds no valid entry.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `flush`  in  1  discard all held entries this cycle.
- `in_valid`  in  1  upstream offers `in_data`.
- `in_ready`  out  1  stage accepts `in_data` this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  `out_data` is a valid entry.
- `out_ready`  in  1  downstream consumes `out_data` this cycle.
- `out_data`  out  DATA_W  oldest held payload.
- `occupancy`  out  2  number of valid entries held (0..2; max 1 when `SKID`=0).

## Operation
- Accept = `in_valid && in_ready`. Consume = `out_valid && out_ready`.
- Storage:
  - main entry (valid bit + data) always drives `out_valid`/`out_data`.
  - skid entry exists only when `SKID`=1.
- States for `SKID`=1: EMPTY (0 entries), ONE (main valid), TWO (main and skid valid).
- `in_ready` = (state != TWO), decoded from state flops only.
- Transitions, evaluated in this order (first match wins):
  - `flush` → EMPTY, from any state. Any accept in the same cycle completes the handshake, but its data is dropped.
  - EMPTY: accept → ONE, main ← `in_data`.
  - ONE, accept and consume → ONE, main ← `in_data`.
  - ONE, consume only → EMPTY.
  - ONE, accept only → TWO, skid ← `in_data`.
  - TWO: consume → ONE, main ← skid; no accept is possible in TWO.
  - Otherwise the state holds.
- `SKID`=0:
  - `in_ready` = `out_ready || !out_valid` (combinational path from `out_ready`).
  - States are EMPTY/ONE only, with the same rules; `flush` has priority.
- Bubble rule: when an entry becomes invalid (consume-to-empty, flush, reset), its data register loads `BUBBLE`. Therefore `out_valid`=0 implies `out_data` = `BUBBLE`.
- Ordering is strict FIFO: payloads leave in acceptance order, none duplicated, none lost except by flush.

## Timing
- Reset values:
  - state EMPTY.
  - `out_valid`=0, `out_data`=`BUBBLE`, `occupancy`=0.
  - `in_ready`=1 (`SKID`=1); `in_ready` = 1 while EMPTY for `SKID`=0.
- Latency: data accepted at edge N appears on `out_data` after edge N with `out_valid`=1. Total latency is 1 cycle with an empty stage, 2 cycles if it enters the skid entry.
- Throughput: 1 entry/cycle while `out_ready`=1.
- After `out_ready` falls, at most one more entry is accepted (into skid). `in_ready` falls at the following edge.
- `flush` takes effect at the next edge: `out_valid`=0 and `occupancy`=0 in the following cycle. `in_ready`=1 in the following cycle for both `SKID` values.
- `rst` asserted mid-transfer clears all state immediately, without waiting for a clock edge. The first accept is possible at the first edge after deassertion.
- `out_valid` and `out_data` depend on flops only.

## Structure
- Package `pipe_pkg` holds the state encoding constants: `ST_EMPTY`=2'd0, `ST_ONE`=2'd1, `ST_TWO`=2'd2.
- Sub-module `pipe_data_reg` (params `DATA_W`, `RST_VAL`):
  - enable-loaded register with asynchronous active-high reset to `RST_VAL`.
  - instantiated once for main and once for skid when `SKID`=1.
- Control FSM stays in `pipe_skid_stage`. The `SKID`=0 path is a generate branch that omits the skid register.

## Test plan
- Reset release, `in_valid`=1 with payloads 0x1000_0001, 0x1000_0002, 0x1000_0003, `out_ready`=1 → outputs 0x…01/02/03 on consecutive cycles, 1-cycle latency, `occupancy`=1.
- `SKID`=1: streaming, then `out_ready`=0 for 3 cycles:
  - exactly one extra accept; `in_ready`=0 next cycle; `occupancy`=2.
  - on release, the two held payloads emerge in order with no gap.
- `flush` in state TWO while `in_valid`=1 with 0xDEAD_BEEF → next cycle `out_valid`=0, `out_data`=`BUBBLE`, `occupancy`=0; 0xDEAD_BEEF never appears on the output.
- `SKID`=0: `out_ready`=0 with main valid → `in_ready`=0 in the same cycle. `out_ready`=1 with `in_valid`=1 → replacement in one cycle, `occupancy` stays 1.
- `rst` pulsed asynchronously mid-cycle in state TWO → outputs return to reset values before the next edge; the post-reset stream starts clean.
- Randomised `in_valid`/`out_ready` (50%) with sparse `flush` → a scoreboard confirms FIFO order and that `out_data` = `BUBBLE` whenever `out_valid`=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the generic pipeline-stage register.
//   state_t : stage fill state. Each encoding equals the number of valid
//             entries held, so the state register is also the occupancy count.
//   OCC_W   : width of the occupancy output.
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage_if
// Handshake bundle around one pipeline stage.
//   flush      : discard all held entries this cycle (master -> stage)
//   in_valid   : upstream offers in_data            (master -> stage)
//   in_ready   : stage accepts in_data this cycle   (stage  -> master)
//   in_data    : upstream payload                   (master -> stage)
//   out_valid  : out_data holds a valid entry       (stage  -> master)
//   out_ready  : downstream consumes out_data       (master -> stage)
//   out_data   : oldest held payload                (stage  -> master)
//   occupancy  : number of valid entries held       (stage  -> master)
// The master modport is the surrounding environment (upstream source plus
// downstream sink); the slave modport is the stage itself.
// -----------------------------------------------------------------------------
interface pipe_skid_stage_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
);

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output flush,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  occupancy
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output occupancy
    );

endinterface

// File: rtl/pipe_data_reg.sv
// -----------------------------------------------------------------------------
// pipe_data_reg
// Enable-loaded payload register with asynchronous active-high reset.
//   clk   : clock, loads on the rising edge
//   rst   : asynchronous active-high reset, forces RST_VAL
//   i_en  : load enable
//   i_d   : next payload
//   o_q   : registered payload
// -----------------------------------------------------------------------------
module pipe_data_reg #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RST_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
// Generic pipeline-stage register with valid/ready handshakes on both sides,
// an optional second (skid) entry and a synchronous flush.
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : pipe_skid_stage_if.slave (flush, in_valid/in_ready/in_data,
//          out_valid/out_ready/out_data, occupancy)
// Parameters:
//   DATA_W : payload width
//   SKID   : 1 = two entries, in_ready decoded from the state register only
//            0 = one entry, in_ready = out_ready || !out_valid
//   BUBBLE : payload shown whenever no valid entry is held
// The main entry always drives out_valid/out_data, so both come straight from
// flops. Every entry that goes invalid reloads BUBBLE into its data register.
// -----------------------------------------------------------------------------
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter bit                SKID   = 1'b1,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  logic               clk,
    input  logic               rst,
    pipe_skid_stage_if.slave   bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_consume;
    logic              w_main_en;
    logic [DATA_W-1:0] w_main_d;
    logic [DATA_W-1:0] w_main_q;
    logic              w_skid_en;
    logic [DATA_W-1:0] w_skid_d;
    logic [DATA_W-1:0] w_skid_q;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_consume   = w_out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and data-register loads. Flush wins over everything; an
    // accept in the flush cycle still completes upstream but is dropped here.
    always_comb begin
        w_state_nxt = r_state;
        w_main_en   = 1'b0;
        w_main_d    = bus.in_data;
        w_skid_en   = 1'b0;
        w_skid_d    = bus.in_data;

        if (bus.flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_en   = 1'b1;
            w_main_d    = BUBBLE;
            w_skid_en   = 1'b1;
            w_skid_d    = BUBBLE;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_main_en   = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        w_main_en = 1'b1;
                    end else if (w_consume) begin
                        w_state_nxt = ST_EMPTY;
                        w_main_en   = 1'b1;
                        w_main_d    = BUBBLE;
                    end else if (w_accept && SKID) begin
                        // Downstream stalled after in_ready was already
                        // promised: park the late entry in the skid slot.
                        w_state_nxt = ST_TWO;
                        w_skid_en   = 1'b1;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a consume can occur.
                    if (w_consume) begin
                        w_state_nxt = ST_ONE;
                        w_main_en   = 1'b1;
                        w_main_d    = w_skid_q;
                        w_skid_en   = 1'b1;
                        w_skid_d    = BUBBLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    pipe_data_reg #(
        .DATA_W  (DATA_W),
        .RST_VAL (BUBBLE)
    ) u_main (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_main_en),
        .i_d  (w_main_d),
        .o_q  (w_main_q)
    );

    generate
        if (SKID) begin : g_skid
            pipe_data_reg #(
                .DATA_W  (DATA_W),
                .RST_VAL (BUBBLE)
            ) u_skid (
                .clk  (clk),
                .rst  (rst),
                .i_en (w_skid_en),
                .i_d  (w_skid_d),
                .o_q  (w_skid_q)
            );

            // The skid slot absorbs the one entry that can arrive after
            // out_ready drops, so in_ready can be a pure flop decode.
            assign w_in_ready = (r_state != ST_TWO);
        end else begin : g_noskid
            // Skid controls have no sink in the single-entry configuration.
            logic w_unused_skid;
            assign w_unused_skid = ^{w_skid_en, w_skid_d};

            assign w_skid_q   = BUBBLE;
            assign w_in_ready = bus.out_ready || !w_out_valid;
        end
    endgenerate

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_main_q;
    // State encoding equals the entry count.
    assign bus.occupancy = OCC_W'(r_state);

endmodule

// File: tb/tb_pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_stage
// Drives one SKID=1 stage (index 0) and one SKID=0 stage (index 1) with the
// same stimulus. Each stage has its own expected-entry queue: accepted
// payloads are pushed, consumed ones popped, flush/reset clear it. A monitor
// per stage compares the outputs against the queue head every cycle, while
// the stimulus process adds directed checks with hand-computed values.
// -----------------------------------------------------------------------------
module tb_pipe_skid_stage;

    localparam logic [31:0] BUB    = 32'hB0B0_B0B0;
    localparam logic [31:0] POISON = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;

    logic        o_rdy   [2];
    logic        o_valid [2];
    logic [31:0] o_data  [2];
    logic [1:0]  o_occ   [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int d,
                                input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d actual=%h required=%h t=%0t", name, d, act, exp, $time);
        end
    endfunction

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            localparam bit SK = (g == 0);

            pipe_skid_stage_if #(.DATA_W(32)) bus ();

            assign bus.flush     = flush;
            assign bus.in_valid  = in_valid;
            assign bus.in_data   = in_data;
            assign bus.out_ready = out_ready;
            assign o_rdy[g]      = bus.in_ready;
            assign o_valid[g]    = bus.out_valid;
            assign o_data[g]     = bus.out_data;
            assign o_occ[g]      = bus.occupancy;

            pipe_skid_stage #(
                .DATA_W (32),
                .SKID   (SK),
                .BUBBLE (BUB)
            ) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (bus.slave)
            );

            logic [31:0] q [$];
            logic        exp_rdy;
            logic [31:0] exp_data;

            initial begin
                forever begin
                    @(negedge clk or posedge rst);
                    if (rst) begin
                        q.delete();
                    end else begin
                        exp_rdy  = SK ? (q.size() < 2) : (out_ready || (q.size() == 0));
                        exp_data = (q.size() != 0) ? q[0] : BUB;
                        chk("mon_in_ready",  g, 32'(o_rdy[g]),   32'(exp_rdy));
                        chk("mon_out_valid", g, 32'(o_valid[g]), 32'(q.size() != 0));
                        chk("mon_out_data",  g, o_data[g],       exp_data);
                        chk("mon_occupancy", g, 32'(o_occ[g]),   32'(q.size()));
                        chk("mon_no_poison", g, 32'(o_valid[g] && (o_data[g] == POISON)), 32'd0);
                        if ((q.size() != 0) && out_ready) begin
                            void'(q.pop_front());
                        end
                        if (flush) begin
                            q.delete();
                        end else if (in_valid && exp_rdy) begin
                            q.push_back(in_data);
                        end
                    end
                end
            end
        end
    endgenerate

    task automatic drive(input logic iv, input logic [31:0] d,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int d, input string nm, input logic v,
                              input logic [31:0] data, input logic [1:0] occ,
                              input logic rdy);
        chk({nm, "_valid"},     d, 32'(o_valid[d]), 32'(v));
        chk({nm, "_data"},      d, o_data[d],       data);
        chk({nm, "_occupancy"}, d, 32'(o_occ[d]),   32'(occ));
        chk({nm, "_in_ready"},  d, 32'(o_rdy[d]),   32'(rdy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        expect_out(0, "reset", 1'b0, BUB, 2'd0, 1'b1);
        expect_out(1, "reset", 1'b0, BUB, 2'd0, 1'b1);
        rst = 1'b0;

        // Streaming with 1-cycle latency.
        drive(1'b1, 32'h1000_0001, 1'b1, 1'b0);
        tick();
        expect_out(0, "stream1", 1'b1, 32'h1000_0001, 2'd1, 1'b1);
        expect_out(1, "stream1", 1'b1, 32'h1000_0001, 2'd1, 1'b1);
        drive(1'b1, 32'h1000_0002, 1'b1, 1'b0);
        tick();
        expect_out(0, "stream2", 1'b1, 32'h1000_0002, 2'd1, 1'b1);
        expect_out(1, "stream2", 1'b1, 32'h1000_0002, 2'd1, 1'b1);
        drive(1'b1, 32'h1000_0003, 1'b1, 1'b0);
        tick();
        expect_out(0, "stream3", 1'b1, 32'h1000_0003, 2'd1, 1'b1);
        expect_out(1, "stream3", 1'b1, 32'h1000_0003, 2'd1, 1'b1);

        // Downstream stalls for 3 cycles.
        drive(1'b1, 32'h1000_0004, 1'b0, 1'b0);
        #1;
        chk("stall_comb_in_ready", 0, 32'(o_rdy[0]), 32'd1);
        chk("stall_comb_in_ready", 1, 32'(o_rdy[1]), 32'd0);
        tick();
        expect_out(0, "stall1", 1'b1, 32'h1000_0003, 2'd2, 1'b0);
        expect_out(1, "stall1", 1'b1, 32'h1000_0003, 2'd1, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        expect_out(0, "stall3", 1'b1, 32'h1000_0003, 2'd2, 1'b0);
        expect_out(1, "stall3", 1'b1, 32'h1000_0003, 2'd1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        expect_out(0, "release1", 1'b1, 32'h1000_0004, 2'd1, 1'b1);
        expect_out(1, "release1", 1'b0, BUB, 2'd0, 1'b1);
        tick();
        expect_out(0, "release2", 1'b0, BUB, 2'd0, 1'b1);

        // Flush while holding two entries, poison offered in the same cycle.
        drive(1'b1, 32'h1100_0011, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h1100_0012, 1'b0, 1'b0);
        tick();
        expect_out(0, "pre_flush", 1'b1, 32'h1100_0011, 2'd2, 1'b0);
        drive(1'b1, POISON, 1'b1, 1'b1);
        tick();
        expect_out(0, "flush_two", 1'b0, BUB, 2'd0, 1'b1);
        expect_out(1, "flush_two", 1'b0, BUB, 2'd0, 1'b1);
        drive(1'b1, POISON, 1'b1, 1'b1);
        tick();
        expect_out(0, "flush_empty", 1'b0, BUB, 2'd0, 1'b1);
        expect_out(1, "flush_empty", 1'b0, BUB, 2'd0, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        expect_out(0, "post_flush", 1'b0, BUB, 2'd0, 1'b1);
        expect_out(1, "post_flush", 1'b0, BUB, 2'd0, 1'b1);

        // Asynchronous reset pulse between edges while holding two entries.
        drive(1'b1, 32'h2100_0021, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h2100_0022, 1'b0, 1'b0);
        tick();
        expect_out(0, "pre_rst", 1'b1, 32'h2100_0021, 2'd2, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        expect_out(0, "async_rst", 1'b0, BUB, 2'd0, 1'b1);
        expect_out(1, "async_rst", 1'b0, BUB, 2'd0, 1'b1);
        #1 rst = 1'b0;
        drive(1'b1, 32'h3100_0031, 1'b1, 1'b0);
        tick();
        expect_out(0, "post_rst1", 1'b1, 32'h3100_0031, 2'd1, 1'b1);
        expect_out(1, "post_rst1", 1'b1, 32'h3100_0031, 2'd1, 1'b1);
        drive(1'b1, 32'h3100_0032, 1'b1, 1'b0);
        tick();
        expect_out(0, "post_rst2", 1'b1, 32'h3100_0032, 2'd1, 1'b1);
        expect_out(1, "post_rst2", 1'b1, 32'h3100_0032, 2'd1, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();

        // Random handshakes with sparse flush; the monitors do the checking.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 32'h4000_0000 + 32'(i),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
            tick();
        end

        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        expect_out(0, "drain", 1'b0, BUB, 2'd0, 1'b1);
        expect_out(1, "drain", 1'b0, BUB, 2'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
